// File: rtl/chacha_block_engine.sv
// ChaCha block function engine: runs NUM_DOUBLE_ROUNDS double rounds on a 16-word state
// with QR_LANES quarter-round units and returns the (optionally fed-forward) keystream block.
`timescale 1ns/1ps
module chacha_block_engine #(
  parameter int NUM_DOUBLE_ROUNDS = 10,
  parameter int QR_LANES          = 1,
  parameter int FEED_FORWARD      = 1,
  parameter int CNT_W             = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_block,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_produced
);

  localparam int RND_W = (NUM_DOUBLE_ROUNDS > 1) ? $clog2(NUM_DOUBLE_ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_DOUBLE_ROUNDS - 1);
  localparam logic [2:0] GRP_STEP = 3'(QR_LANES);
  localparam logic [2:0] LAST_GRP = 3'(8 - QR_LANES);

  if (!(NUM_DOUBLE_ROUNDS == 4 || NUM_DOUBLE_ROUNDS == 6 || NUM_DOUBLE_ROUNDS == 10) ||
      !(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_param_check
    $error("chacha_block_engine: illegal NUM_DOUBLE_ROUNDS or QR_LANES");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  state_t           state, state_d;
  logic [RND_W-1:0] rnd;
  logic [2:0]       grp;
  logic [31:0]      work     [16];
  logic [31:0]      saved    [16];
  logic [31:0]      work_nxt [16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter_round(input logic [127:0] abcd);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = abcd;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  // Q0-Q3 take column j; Q4-Q7 take the diagonal starting at column j,
  // whose row-r word sits in column (j+r) mod 4 (2-bit wrap does the mod).
  function automatic logic [3:0] qr_word(input logic [2:0] q, input logic [1:0] row);
    logic [1:0] col;
    col = q[2] ? (q[1:0] + row) : q[1:0];
    return {row, col};
  endfunction

  always_comb begin
    work_nxt = work;
    for (int k = 0; k < QR_LANES; k++) begin
      logic [2:0]   q;
      logic [127:0] r;
      q = grp + 3'(k);
      r = quarter_round({work[qr_word(q, 2'd3)], work[qr_word(q, 2'd2)],
                         work[qr_word(q, 2'd1)], work[qr_word(q, 2'd0)]});
      work_nxt[qr_word(q, 2'd0)] = r[31:0];
      work_nxt[qr_word(q, 2'd1)] = r[63:32];
      work_nxt[qr_word(q, 2'd2)] = r[95:64];
      work_nxt[qr_word(q, 2'd3)] = r[127:96];
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = ROUND;
      ROUND:   if (grp == LAST_GRP && rnd == LAST_RND) state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state == ROUND) || (state == FINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rnd             <= '0;
      grp             <= '0;
      out_block       <= '0;
      blocks_produced <= '0;
      for (int i = 0; i < 16; i++) begin
        work[i]  <= '0;
        saved[i] <= '0;
      end
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (in_valid) begin
          rnd <= '0;
          grp <= '0;
          for (int i = 0; i < 16; i++) begin
            work[i]  <= in_state[32*i +: 32];
            saved[i] <= in_state[32*i +: 32];
          end
        end
        // one lane group per cycle; group index wraps 8 -> 0 at the end of each double round
        ROUND: begin
          work <= work_nxt;
          grp  <= grp + GRP_STEP;
          if (grp == LAST_GRP) rnd <= rnd + RND_W'(1);
        end
        FINAL: begin
          for (int i = 0; i < 16; i++)
            out_block[32*i +: 32] <= (FEED_FORWARD != 0) ? work[i] + saved[i] : work[i];
        end
        OUT: if (out_ready) blocks_produced <= blocks_produced + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Directed bench for chacha_block_engine: RFC 8439 vector across lane/feed-forward variants,
// output stall, mid-block reset and counter wrap over random blocks.
`timescale 1ns/1ps
module tb_chacha_block_engine;

  localparam logic [511:0] RFC_IN = {
    32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
    32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
    32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  localparam logic [511:0] RFC_OUT = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  logic               clk = 1'b0;
  logic               rst_n;
  logic [511:0]       in_state;
  logic [3:0]         in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
  logic [3:0][511:0]  out_block_v;
  logic [3:0][3:0]    cnt_v;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chacha_block_engine u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_block(out_block_v[0]), .busy(busy_v[0]), .blocks_produced(cnt_v[0]));

  chacha_block_engine #(.QR_LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_block(out_block_v[1]), .busy(busy_v[1]), .blocks_produced(cnt_v[1]));

  chacha_block_engine #(.QR_LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_block(out_block_v[2]), .busy(busy_v[2]), .blocks_produced(cnt_v[2]));

  chacha_block_engine #(.FEED_FORWARD(0)) u_nf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_state(in_state), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .out_block(out_block_v[3]), .busy(busy_v[3]), .blocks_produced(cnt_v[3]));

  function automatic logic [511:0] mqr(input logic [511:0] s, input int a, input int b,
                                       input int c, input int d);
    logic [31:0] xa, xb, xc, xd;
    xa = s[32*a +: 32]; xb = s[32*b +: 32]; xc = s[32*c +: 32]; xd = s[32*d +: 32];
    xa += xb; xd ^= xa; xd = {xd[15:0], xd[31:16]};
    xc += xd; xb ^= xc; xb = {xb[19:0], xb[31:20]};
    xa += xb; xd ^= xa; xd = {xd[23:0], xd[31:24]};
    xc += xd; xb ^= xc; xb = {xb[24:0], xb[31:25]};
    s[32*a +: 32] = xa; s[32*b +: 32] = xb; s[32*c +: 32] = xc; s[32*d +: 32] = xd;
    return s;
  endfunction

  function automatic logic [511:0] chacha_model(input logic [511:0] st);
    logic [511:0] s;
    s = st;
    for (int r = 0; r < 10; r++) begin
      s = mqr(s, 0, 4, 8, 12); s = mqr(s, 1, 5, 9, 13);
      s = mqr(s, 2, 6, 10, 14); s = mqr(s, 3, 7, 11, 15);
      s = mqr(s, 0, 5, 10, 15); s = mqr(s, 1, 6, 11, 12);
      s = mqr(s, 2, 7, 8, 13); s = mqr(s, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) s[32*i +: 32] = s[32*i +: 32] + st[32*i +: 32];
    return s;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [511:0] st, input bit scramble, output int lat);
    logic [511:0] junk;
    @(negedge clk);
    in_state      = st;
    in_valid_v[i] = 1'b1;
    check("in_ready_before_accept", 512'(in_ready_v[i]), 512'd1);
    @(posedge clk); #1;
    if (!scramble) in_valid_v[i] = 1'b0;
    check("busy_after_accept", 512'(busy_v[i]), 512'd1);
    lat = 0;
    while (!out_valid_v[i] && lat < 200) begin
      if (scramble) begin
        for (int w = 0; w < 16; w++) junk[32*w +: 32] = $urandom();
        in_state = junk;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid_v[i] = 1'b0;
  endtask

  task automatic recv(input int i, input bit valid_too, output logic [511:0] blk);
    blk = out_block_v[i];
    @(negedge clk);
    out_ready_v[i] = 1'b1;
    if (valid_too) in_valid_v[i] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[i] = 1'b0;
    check("in_ready_after_handshake", 512'(in_ready_v[i]), 512'd1);
    check("busy_after_handshake", 512'(busy_v[i]), 512'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat;
    logic [511:0] blk, held, sum, rnd_in;

    rst_n = 1'b0; in_state = '0;
    in_valid_v = '0; out_ready_v = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 512'(in_ready_v[0]), 512'd1);
    check("reset_out_valid", 512'(out_valid_v[0]), 512'd0);
    check("reset_busy", 512'(busy_v[0]), 512'd0);
    check("reset_out_block", out_block_v[0], 512'd0);
    check("reset_count", 512'(cnt_v[0]), 512'd0);
    @(negedge clk); rst_n = 1'b1;

    // RFC vector at defaults, then a 50-cycle output stall
    send(0, RFC_IN, 1'b0, lat);
    check("latency_lanes1", 512'(lat), 512'd81);
    check("rfc_word0", 512'(out_block_v[0][31:0]), 512'(32'he4e7f110));
    check("rfc_word1", 512'(out_block_v[0][63:32]), 512'(32'h15593bd1));
    check("rfc_word15", 512'(out_block_v[0][511:480]), 512'(32'h4e3c50a2));
    check("rfc_block", out_block_v[0], RFC_OUT);
    held = out_block_v[0];
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check("stall_block", out_block_v[0], held);
      check("stall_out_valid", 512'(out_valid_v[0]), 512'd1);
      check("stall_in_ready", 512'(in_ready_v[0]), 512'd0);
      check("stall_count", 512'(cnt_v[0]), 512'd0);
    end
    recv(0, 1'b0, blk);
    check("count_after_first", 512'(cnt_v[0]), 512'd1);

    send(1, RFC_IN, 1'b0, lat);
    check("latency_lanes2", 512'(lat), 512'd41);
    check("rfc_block_lanes2", out_block_v[1], RFC_OUT);
    recv(1, 1'b0, blk);
    check("count_lanes2", 512'(cnt_v[1]), 512'd1);

    send(2, RFC_IN, 1'b0, lat);
    check("latency_lanes4", 512'(lat), 512'd21);
    check("rfc_block_lanes4", out_block_v[2], RFC_OUT);
    recv(2, 1'b0, blk);

    send(3, RFC_IN, 1'b0, lat);
    check("latency_no_ff", 512'(lat), 512'd81);
    for (int w = 0; w < 16; w++) sum[32*w +: 32] = out_block_v[3][32*w +: 32] + RFC_IN[32*w +: 32];
    check("no_ff_plus_input", sum, RFC_OUT);
    recv(3, 1'b0, blk);

    // asynchronous reset in the middle of ROUND
    @(negedge clk);
    in_state = RFC_IN; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 512'(in_ready_v[0]), 512'd1);
    check("midreset_busy", 512'(busy_v[0]), 512'd0);
    check("midreset_out_valid", 512'(out_valid_v[0]), 512'd0);
    check("midreset_out_block", out_block_v[0], 512'd0);
    check("midreset_count", 512'(cnt_v[0]), 512'd0);
    @(negedge clk); rst_n = 1'b1;
    send(0, RFC_IN, 1'b0, lat);
    check("post_reset_latency", 512'(lat), 512'd81);
    check("post_reset_block", out_block_v[0], RFC_OUT);
    recv(0, 1'b0, blk);
    check("post_reset_count", 512'(cnt_v[0]), 512'd1);

    // 17 back-to-back random blocks with in_state scrambled during ROUND
    reset_pulse();
    for (int b = 0; b < 17; b++) begin
      for (int w = 0; w < 16; w++) rnd_in[32*w +: 32] = $urandom();
      send(0, rnd_in, 1'b1, lat);
      check("rand_latency", 512'(lat), 512'd81);
      check("rand_block", out_block_v[0], chacha_model(rnd_in));
      recv(0, (b != 16), blk);
      check("rand_count", 512'(cnt_v[0]), 512'((b + 1) % 16));
    end
    check("count_wrapped", 512'(cnt_v[0]), 512'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
